dr_chain: RTL and testbench

DR_CHAIN -- requirements
Module: dr_chain

---
 rtl/dr_chain_if.sv | 43 ++++
 rtl/dr_chain.sv | 143 ++++++++++++++
 tb/tb_dr_chain.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dr_chain_if.sv
// dr_chain_if: TAP-side data-register bus for dr_chain.
// Carries the serial path (TDI/TDO), the TAP DR state strobes, the decoded
// instruction selects, and the boundary pin interface.
//   master : TAP controller / instruction decoder (drives strobes and selects)
//   slave  : dr_chain (drives TDO, BSR_OUT, BSR_OE, SHIFT_CNT)
interface dr_chain_if #(
  parameter int unsigned BSR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 TDI;
  logic                 CAPTUREDR;
  logic                 SHIFTDR;
  logic                 UPDATEDR;
  logic                 BYPASS_SELECT;
  logic                 SAMPLE_SELECT;
  logic                 EXTEST_SELECT;
  logic                 INTEST_SELECT;
  logic                 CLAMP_SELECT;
  logic                 HIGHZ_SELECT;
  logic                 IDCODE_SELECT;
  logic                 USERCODE_SELECT;
  logic [BSR_WIDTH-1:0] PIN_IN;
  logic [BSR_WIDTH-1:0] BSR_OUT;
  logic                 BSR_OE;
  logic                 TDO;
  logic [CNT_WIDTH-1:0] SHIFT_CNT;

  modport master (
    output TDI, CAPTUREDR, SHIFTDR, UPDATEDR,
    output BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT,
    output CLAMP_SELECT, HIGHZ_SELECT, IDCODE_SELECT, USERCODE_SELECT,
    output PIN_IN,
    input  BSR_OUT, BSR_OE, TDO, SHIFT_CNT
  );

  modport slave (
    input  TDI, CAPTUREDR, SHIFTDR, UPDATEDR,
    input  BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT,
    input  CLAMP_SELECT, HIGHZ_SELECT, IDCODE_SELECT, USERCODE_SELECT,
    input  PIN_IN,
    output BSR_OUT, BSR_OE, TDO, SHIFT_CNT
  );
endinterface

// File: rtl/dr_chain.sv
// dr_chain: JTAG data-register chain (BSR, IDCODE, optional USERCODE, BYPASS).
// Ports:
//   TCK   - sole clock; all state on posedge except TDO (negedge)
//   TRST  - asynchronous active-high reset
//   dr    - dr_chain_if.slave: TDI, CAPTUREDR/SHIFTDR/UPDATEDR, instruction
//           selects, PIN_IN in; TDO, BSR_OUT, BSR_OE, SHIFT_CNT out
// Build option: define DR_CHAIN_USERCODE_EN to include the USERCODE register;
// without it USERCODE_SELECT routes through the bypass bit.
module dr_chain #(
  parameter int unsigned         BSR_WIDTH  = 8,
  parameter int unsigned         ID_WIDTH   = 32,
  parameter logic [ID_WIDTH-1:0] ID_VALUE   = ID_WIDTH'(32'h000000A1),
  parameter logic [ID_WIDTH-1:0] USER_VALUE = ID_WIDTH'(32'h00000099),
  parameter int unsigned         CNT_WIDTH  = 8
) (
  input  logic       TCK,
  input  logic       TRST,
  dr_chain_if.slave  dr
);

  logic                 sel_id;
  logic                 sel_bsr;
  logic                 highz_c;
  logic                 tdo_c;
  logic [BSR_WIDTH-1:0] bsr_sr;
  logic [BSR_WIDTH-1:0] bsr_out;
  logic [ID_WIDTH-1:0]  id_sr;
  logic                 byp_sr;
  logic [CNT_WIDTH-1:0] shift_cnt;
  logic                 tdo_q;
`ifdef DR_CHAIN_USERCODE_EN
  logic                 sel_user;
  logic [ID_WIDTH-1:0]  user_sr;
`endif

  // Instruction priority: IDCODE > USERCODE > SAMPLE/EXTEST/INTEST > rest (bypass)
  always_comb begin
    sel_id   = 1'b0;
    sel_bsr  = 1'b0;
    highz_c  = 1'b0;
`ifdef DR_CHAIN_USERCODE_EN
    sel_user = 1'b0;
`endif
    if (dr.IDCODE_SELECT) begin
      sel_id = 1'b1;
    end else if (dr.USERCODE_SELECT) begin
`ifdef DR_CHAIN_USERCODE_EN
      sel_user = 1'b1;
`endif
      // without the USERCODE register this falls to the bypass bit
    end else if (dr.SAMPLE_SELECT || dr.EXTEST_SELECT || dr.INTEST_SELECT) begin
      sel_bsr = 1'b1;
    end else begin
      highz_c = dr.HIGHZ_SELECT;
    end
  end

  // Serial output mux: LSB of the selected shift register
  always_comb begin
    tdo_c = byp_sr;
    if (sel_id) begin
      tdo_c = id_sr[0];
`ifdef DR_CHAIN_USERCODE_EN
    end else if (sel_user) begin
      tdo_c = user_sr[0];
`endif
    end else if (sel_bsr) begin
      tdo_c = bsr_sr[0];
    end
  end

  // Shift registers: capture beats shift; only the selected register moves
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bsr_sr  <= '0;
      id_sr   <= ID_VALUE;
      byp_sr  <= 1'b0;
`ifdef DR_CHAIN_USERCODE_EN
      user_sr <= USER_VALUE;
`endif
    end else if (dr.CAPTUREDR) begin
      if (sel_id) begin
        id_sr <= ID_VALUE;
`ifdef DR_CHAIN_USERCODE_EN
      end else if (sel_user) begin
        user_sr <= USER_VALUE;
`endif
      end else if (sel_bsr) begin
        bsr_sr <= dr.PIN_IN;
      end else begin
        byp_sr <= 1'b0;
      end
    end else if (dr.SHIFTDR) begin
      // {TDI, reg} >> 1 places TDI in the MSB and works for 1-bit registers
      if (sel_id) begin
        id_sr <= ID_WIDTH'({dr.TDI, id_sr} >> 1);
`ifdef DR_CHAIN_USERCODE_EN
      end else if (sel_user) begin
        user_sr <= ID_WIDTH'({dr.TDI, user_sr} >> 1);
`endif
      end else if (sel_bsr) begin
        bsr_sr <= BSR_WIDTH'({dr.TDI, bsr_sr} >> 1);
      end else begin
        byp_sr <= dr.TDI;
      end
    end
  end

  // Shift counter: cleared on capture, saturating increment on shift
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      shift_cnt <= '0;
    end else if (dr.CAPTUREDR) begin
      shift_cnt <= '0;
    end else if (dr.SHIFTDR && (shift_cnt != {CNT_WIDTH{1'b1}})) begin
      shift_cnt <= shift_cnt + CNT_WIDTH'(1);
    end
  end

  // Update latch: only boundary-scan instructions drive new pin values
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bsr_out <= '0;
    end else if (dr.UPDATEDR && sel_bsr) begin
      bsr_out <= bsr_sr;
    end
  end

  // TDO retimed on the falling edge
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= tdo_c;
    end
  end

  assign dr.TDO       = tdo_q;
  assign dr.BSR_OUT   = bsr_out;
  assign dr.BSR_OE    = ~highz_c;
  assign dr.SHIFT_CNT = shift_cnt;

endmodule

// File: tb/tb_dr_chain.sv
// tb_dr_chain: directed stimulus for dr_chain with a queued scoreboard.
// Stimulus sets inputs, queues what the outputs must read after the next
// posedge/negedge pair, then advances; the monitor compares each window.
module tb_dr_chain;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 8;
  localparam int F_TDO = 0;
  localparam int F_OUT = 1;
  localparam int F_OE  = 2;
  localparam int F_CNT = 3;

  logic tck = 1'b0;
  logic trst;
  always #5 tck = ~tck;

  dr_chain_if #(.BSR_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

  dr_chain #(
    .BSR_WIDTH (BW),
    .ID_WIDTH  (32),
    .ID_VALUE  (32'h000000A1),
    .USER_VALUE(32'h00000099),
    .CNT_WIDTH (CW)
  ) dut (
    .TCK (tck),
    .TRST(trst),
    .dr  (bus)
  );

  typedef struct {
    int          win;
    int          fld;
    logic [31:0] val;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   win   = 0;
  int   total = 0;
  int   bad   = 0;
  int   tag   = 0;

  function automatic string fname(input int f);
    case (f)
      F_TDO:   return "TDO";
      F_OUT:   return "BSR_OUT";
      F_OE:    return "BSR_OE";
      default: return "SHIFT_CNT";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int f);
    case (f)
      F_TDO:   return 32'(bus.TDO);
      F_OUT:   return 32'(bus.BSR_OUT);
      F_OE:    return 32'(bus.BSR_OE);
      default: return 32'(bus.SHIFT_CNT);
    endcase
  endfunction

  task automatic exp_next(input int fld, input logic [31:0] v);
    exp_t e;
    e.win = win + 1;
    e.fld = fld;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge tck);
    @(negedge tck);
    #2;
  endtask

  task automatic idle();
    bus.TDI             = 1'b0;
    bus.CAPTUREDR       = 1'b0;
    bus.SHIFTDR         = 1'b0;
    bus.UPDATEDR        = 1'b0;
    bus.BYPASS_SELECT   = 1'b0;
    bus.SAMPLE_SELECT   = 1'b0;
    bus.EXTEST_SELECT   = 1'b0;
    bus.INTEST_SELECT   = 1'b0;
    bus.CLAMP_SELECT    = 1'b0;
    bus.HIGHZ_SELECT    = 1'b0;
    bus.IDCODE_SELECT   = 1'b0;
    bus.USERCODE_SELECT = 1'b0;
  endtask

  task automatic shift(input logic tdi);
    bus.CAPTUREDR = 1'b0;
    bus.UPDATEDR  = 1'b0;
    bus.SHIFTDR   = 1'b1;
    bus.TDI       = tdi;
  endtask

  task automatic update();
    bus.CAPTUREDR = 1'b0;
    bus.SHIFTDR   = 1'b0;
    bus.UPDATEDR  = 1'b1;
  endtask

  // Monitor: one observation window per TCK, just after the TDO edge
  initial begin
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge tck);
      win++;
      #1;
      while (sb.size() > 0 && sb[0].win <= win) begin
        e = sb.pop_front();
        a = actual(e.fld);
        total++;
        if (e.win != win || a !== e.val) begin
          bad++;
          $display("FAIL %s tag=%0d win=%0d got=%0h want=%0h",
                   fname(e.fld), e.tag, win, a, e.val);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] idv;
    logic [7:0]  pin;
    logic [7:0]  pat;
    exp_t        e;
    idv = 32'h000000A1;

    // reset values while TRST held
    trst = 1'b1;
    bus.PIN_IN = 8'h00;
    idle();
    tick();
    exp_next(F_TDO, 0); exp_next(F_OUT, 0); exp_next(F_CNT, 0); exp_next(F_OE, 1);
    tick();
    total++;
    if (bus.TDO !== 1'b0) begin
      bad++;
      $display("FAIL direct reset TDO got=%0h", bus.TDO);
    end
    total++;
    if (bus.BSR_OUT !== 8'h00) begin
      bad++;
      $display("FAIL direct reset BSR_OUT got=%0h", bus.BSR_OUT);
    end
    total++;
    if (bus.SHIFT_CNT !== 8'd0) begin
      bad++;
      $display("FAIL direct reset SHIFT_CNT got=%0h", bus.SHIFT_CNT);
    end
    trst = 1'b0;
    tick();

    // IDCODE: capture then 32 zero shifts, LSB first
    tag = 1;
    bus.IDCODE_SELECT = 1'b1; bus.CAPTUREDR = 1'b1;
    exp_next(F_TDO, 32'(idv[0])); exp_next(F_CNT, 0);
    tick();
    for (int k = 1; k <= 32; k++) begin
      shift(1'b0);
      exp_next(F_TDO, (idv >> k) & 32'd1);
      if (k == 32) exp_next(F_CNT, 32);
      tick();
    end
    total++;
    if (bus.SHIFT_CNT !== 8'd32) begin
      bad++;
      $display("FAIL direct IDCODE SHIFT_CNT got=%0d", bus.SHIFT_CNT);
    end

    // EXTEST: capture 0F, shift in 5A, update
    tag = 2;
    idle(); bus.EXTEST_SELECT = 1'b1; pin = 8'h0F; bus.PIN_IN = pin; bus.CAPTUREDR = 1'b1;
    exp_next(F_TDO, 1);
    tick();
    pat = 8'h5A;
    for (int k = 1; k <= 8; k++) begin
      shift(pat[k-1]);
      if (k < 8) exp_next(F_TDO, 32'(pin[k]));
      else begin
        exp_next(F_TDO, 32'(pat[0]));
        exp_next(F_OUT, 0);
      end
      tick();
    end
    update();
    exp_next(F_OUT, 32'h5A); exp_next(F_OE, 1);
    tick();
    total++;
    if (bus.BSR_OUT !== 8'h5A) begin
      bad++;
      $display("FAIL direct EXTEST BSR_OUT got=%0h", bus.BSR_OUT);
    end
    total++;
    if (bus.BSR_OE !== 1'b1) begin
      bad++;
      $display("FAIL direct EXTEST BSR_OE got=%0h", bus.BSR_OE);
    end

    // SAMPLE: capture C3, shift ones, BSR_OUT held until update
    tag = 3;
    idle(); bus.SAMPLE_SELECT = 1'b1; pin = 8'hC3; bus.PIN_IN = pin; bus.CAPTUREDR = 1'b1;
    exp_next(F_TDO, 1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      shift(1'b1);
      exp_next(F_TDO, (k < 8) ? 32'(pin[k]) : 32'd1);
      exp_next(F_OUT, 32'h5A);
      tick();
    end
    update();
    exp_next(F_OUT, 32'hFF);
    tick();

    // BYPASS (no select): captured 0 then TDI delayed one cycle
    tag = 4;
    idle(); bus.CAPTUREDR = 1'b1;
    exp_next(F_TDO, 0);
    tick();
    shift(1'b1); exp_next(F_TDO, 1); tick();
    shift(1'b0); exp_next(F_TDO, 0); tick();
    shift(1'b1); exp_next(F_TDO, 1); exp_next(F_OE, 1); exp_next(F_CNT, 3); tick();
    // capture and shift together: capture wins
    bus.CAPTUREDR = 1'b1; bus.SHIFTDR = 1'b1; bus.TDI = 1'b1;
    exp_next(F_TDO, 0); exp_next(F_CNT, 0);
    tick();
    idle(); bus.HIGHZ_SELECT = 1'b1; shift(1'b1);
    exp_next(F_OE, 0); exp_next(F_TDO, 1);
    tick();
    total++;
    if (bus.BSR_OE !== 1'b0) begin
      bad++;
      $display("FAIL direct HIGHZ BSR_OE got=%0h", bus.BSR_OE);
    end
    idle(); bus.CLAMP_SELECT = 1'b1;
    exp_next(F_OE, 1);
    tick();
    idle(); bus.HIGHZ_SELECT = 1'b1; bus.SAMPLE_SELECT = 1'b1;
    exp_next(F_OE, 1);
    tick();

    // TRST during EXTEST shift aborts, no update
    tag = 5;
    idle(); bus.EXTEST_SELECT = 1'b1; bus.PIN_IN = 8'hFF; bus.CAPTUREDR = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      shift(1'b1);
      if (k == 4) exp_next(F_CNT, 4);
      tick();
    end
    trst = 1'b1;
    exp_next(F_OUT, 0); exp_next(F_TDO, 0); exp_next(F_CNT, 0);
    tick();
    trst = 1'b0;
    update();
    exp_next(F_OUT, 0);
    tick();
    shift(1'b1); exp_next(F_CNT, 1); tick();
    update(); exp_next(F_OUT, 32'h80); tick();

    // counter saturation over 300 shifts
    tag = 6;
    idle(); bus.CAPTUREDR = 1'b1;
    tick();
    for (int k = 1; k <= 300; k++) begin
      shift(1'b0);
      if (k == 254) exp_next(F_CNT, 254);
      if (k == 255 || k == 300) exp_next(F_CNT, 255);
      tick();
    end
    total++;
    if (bus.SHIFT_CNT !== 8'd255) begin
      bad++;
      $display("FAIL direct saturation SHIFT_CNT got=%0d", bus.SHIFT_CNT);
    end

    // USERCODE select (also outranks SAMPLE)
    tag = 7;
    idle(); bus.USERCODE_SELECT = 1'b1; bus.SAMPLE_SELECT = 1'b1;
    bus.PIN_IN = 8'hFF; bus.CAPTUREDR = 1'b1;
`ifdef DR_CHAIN_USERCODE_EN
    exp_next(F_TDO, 1); tick();
    shift(1'b1); exp_next(F_TDO, 0); tick();
    shift(1'b0); exp_next(F_TDO, 0); tick();
`else
    exp_next(F_TDO, 0); tick();
    shift(1'b1); exp_next(F_TDO, 1); tick();
    shift(1'b0); exp_next(F_TDO, 0); tick();
`endif

    // select change mid-shift: IDCODE keeps its partial contents
    tag = 8;
    idle(); bus.IDCODE_SELECT = 1'b1; bus.CAPTUREDR = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      shift(1'b0);
      exp_next(F_TDO, (idv >> k) & 32'd1);
      tick();
    end
    bus.IDCODE_SELECT = 1'b0; shift(1'b1);
    exp_next(F_TDO, 1);
    tick();
    bus.IDCODE_SELECT = 1'b1; shift(1'b0);
    exp_next(F_TDO, (idv >> 5) & 32'd1);
    tick();

    idle();
    tick();
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s tag=%0d never observed want=%0h", fname(e.fld), e.tag, e.val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
